// File: rtl/lut_bank_if.sv
// Lookup-sum bank bus: coefficient write port, lookup request and result.
// master drives requests (bench or upstream), slave is the lut_bank.
interface lut_bank_if #(
  parameter int unsigned N         = 12,
  parameter int unsigned DataWidth = 16
);
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned OW = DataWidth + $clog2(N);

  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic signed [DataWidth-1:0] wr_data;
  logic                        busy;
  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0]                sel;
  logic                        out_valid;
  logic signed [OW-1:0]        result;

  modport master (
    output wr_en, wr_addr, wr_data, in_valid, sel,
    input  busy, in_ready, out_valid, result
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, in_valid, sel,
    output busy, in_ready, out_valid, result
  );
endinterface

// File: rtl/lut_bank.sv
// Runtime-programmable partitioned look-up sum: result = sum_j (sel[j] ? +fact[j] : -fact[j]).
// One sub-table per LutSize select bits; a rebuild FSM regenerates a table after a coefficient write.
module lut_bank #(
  parameter int unsigned N         = 12,
  parameter int unsigned LutSize   = 4,
  parameter int unsigned DataWidth = 16
) (
  input logic       clk,
  input logic       rst,
  lut_bank_if.slave bus
);
  localparam int unsigned M       = (N + LutSize - 1) / LutSize;
  localparam int unsigned Entries = 1 << LutSize;
  localparam int unsigned PadN    = M * LutSize;
  // One bit of headroom beyond the nominal width so an all-minimum-coefficient entry cannot wrap.
  localparam int unsigned EW      = DataWidth + $clog2(LutSize + 1);
  localparam int unsigned OW      = DataWidth + $clog2(N);
  localparam int unsigned GW      = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [0:0] {StIdle, StBuild} state_e;

  state_e                      state_q, state_d;
  logic [GW-1:0]               grp_q, grp_d;
  logic [LutSize-1:0]          cnt_q, cnt_d;
  logic signed [DataWidth-1:0] fact_q [N];
  logic signed [EW-1:0]        table_q [M][Entries];
  logic signed [EW-1:0]        part_q [M];
  logic                        v1_q;
  logic                        out_valid_q;
  logic signed [OW-1:0]        result_q;

  logic                        busy;
  logic                        wr_accept;
  logic                        lookup_accept;
  logic                        build_last;
  logic signed [DataWidth-1:0] fact_pad [PadN];
  logic [PadN-1:0]             sel_pad;
  logic signed [EW-1:0]        build_entry;
  logic signed [OW-1:0]        sum;

  assign busy          = (state_q == StBuild);
  assign bus.busy      = busy;
  assign bus.in_ready  = ~busy;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  assign wr_accept     = bus.wr_en && (state_q == StIdle) && (32'(bus.wr_addr) < N);
  assign lookup_accept = bus.in_valid && ~busy;
  assign build_last    = &cnt_q;

  // Zero-padded views so the last group can be treated like the others.
  always_comb begin
    for (int j = 0; j < PadN; j++) fact_pad[j] = '0;
    for (int j = 0; j < N; j++) fact_pad[j] = fact_q[j];
    sel_pad        = '0;
    sel_pad[N-1:0] = bus.sel;
  end

  // Rebuild FSM.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (wr_accept) begin
          state_d = StBuild;
          grp_d   = GW'(32'(bus.wr_addr) / LutSize);
          cnt_d   = '0;
        end
      end
      StBuild: begin
        cnt_d = cnt_q + 1'b1;
        if (build_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < N; j++) fact_q[j] <= '0;
    end else if (wr_accept) begin
      fact_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Entry cnt_q of table grp_q, built from the live coefficient registers.
  always_comb begin
    logic signed [DataWidth-1:0] c;
    build_entry = '0;
    for (int i = 0; i < LutSize; i++) begin
      c = '0;
      for (int g = 0; g < M; g++) begin
        if (grp_q == GW'(g)) c = fact_pad[g*LutSize+i];
      end
      if (cnt_q[i]) build_entry = build_entry + EW'(c);
      else          build_entry = build_entry - EW'(c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < M; g++) begin
        for (int k = 0; k < Entries; k++) table_q[g][k] <= '0;
      end
    end else if (state_q == StBuild) begin
      table_q[grp_q][cnt_q] <= build_entry;
    end
  end

  always_comb begin
    sum = '0;
    for (int g = 0; g < M; g++) sum = sum + OW'(part_q[g]);
  end

  // Stage 1 registers partial reads, stage 2 the summed result; result holds across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < M; g++) part_q[g] <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      v1_q        <= lookup_accept;
      out_valid_q <= v1_q;
      if (lookup_accept) begin
        for (int g = 0; g < M; g++) part_q[g] <= table_q[g][sel_pad[g*LutSize +: LutSize]];
      end
      if (v1_q) result_q <= sum;
    end
  end
endmodule

// File: tb/tb_lut_bank.sv
// Randomized self-checking bench for lut_bank in two configurations (12/4/16 and 4/2/8),
// compared every cycle against a coefficient-array model with a 2-cycle result queue.
module tb_lut_bank;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_bank_if #(.N(12), .DataWidth(16)) bus_a ();
  lut_bank_if #(.N(4),  .DataWidth(8))  bus_b ();

  lut_bank #(.N(12), .LutSize(4), .DataWidth(16)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  lut_bank #(.N(4),  .LutSize(2), .DataWidth(8))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    int inst;
    int due;
    int val;
  } exp_t;

  exp_t pend[$];
  int   fact      [2][12];
  int   busy_left [2];
  int   last_res  [2];
  int   nn        [2] = '{12, 4};
  int   depth     [2] = '{16, 4};
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_sum(input int d, input logic [11:0] s);
    int acc = 0;
    for (int j = 0; j < nn[d]; j++) acc += s[j] ? fact[d][j] : -fact[d][j];
    return acc;
  endfunction

  // Effect of one rising edge on the model: lookups read coefficients before any write lands.
  task automatic model_edge(input int d, input logic iv, input logic [11:0] s,
                            input logic we, input int addr, input int data);
    exp_t e;
    if (iv && busy_left[d] == 0) begin
      e.inst = d;
      e.due  = cyc + 2;
      e.val  = model_sum(d, s);
      pend.push_back(e);
    end
    if (busy_left[d] > 0) busy_left[d]--;
    else if (we && addr < nn[d]) begin
      fact[d][addr] = data;
      busy_left[d]  = depth[d];
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      bit                 hit;
      logic               ov, bz, rdy;
      logic signed [31:0] res;
      hit = 1'b0;
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].inst == d && pend[i].due == cyc) begin
          hit         = 1'b1;
          last_res[d] = pend[i].val;
          pend.delete(i);
          break;
        end
      end
      if (d == 0) begin
        ov = bus_a.out_valid; bz = bus_a.busy; rdy = bus_a.in_ready; res = $signed(bus_a.result);
      end else begin
        ov = bus_b.out_valid; bz = bus_b.busy; rdy = bus_b.in_ready; res = $signed(bus_b.result);
      end
      check(d == 0 ? "a_out_valid" : "b_out_valid", {31'b0, ov}, int'(hit));
      check(d == 0 ? "a_result" : "b_result", res, last_res[d]);
      check(d == 0 ? "a_busy" : "b_busy", {31'b0, bz}, int'(busy_left[d] > 0));
      check(d == 0 ? "a_in_ready" : "b_in_ready", {31'b0, rdy}, int'(busy_left[d] == 0));
    end
  endtask

  task automatic tick();
    model_edge(0, bus_a.in_valid, bus_a.sel, bus_a.wr_en, int'(bus_a.wr_addr),
               int'(bus_a.wr_data));
    model_edge(1, bus_b.in_valid, {8'h0, bus_b.sel}, bus_b.wr_en, int'(bus_b.wr_addr),
               int'(bus_b.wr_data));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.in_valid = 1'b0;
    bus_a.sel = '0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.in_valid = 1'b0;
    bus_b.sel = '0;
  endtask

  task automatic set_write(input int d, input int addr, input int data);
    if (d == 0) begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'(addr); bus_a.wr_data = 16'(data);
    end else begin
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 2'(addr); bus_b.wr_data = 8'(data);
    end
  endtask

  task automatic set_lookup(input int d, input logic iv, input logic [11:0] s);
    if (d == 0) begin
      bus_a.in_valid = iv; bus_a.sel = s;
    end else begin
      bus_b.in_valid = iv; bus_b.sel = s[3:0];
    end
  endtask

  // Accepted write, then ride out the model's busy window.
  task automatic write(input int d, input int addr, input int data);
    set_write(d, addr, data);
    tick();
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
    while (busy_left[d] > 0) tick();
  endtask

  task automatic lookup(input int d, input logic [11:0] s);
    set_lookup(d, 1'b1, s);
    tick();
    set_lookup(d, 1'b0, s);
    tick();
    tick();
  endtask

  task automatic random_cycles(input int n, input bit with_writes);
    for (int c = 0; c < n; c++) begin
      bus_a.in_valid = 1'($urandom);
      bus_a.sel      = 12'($urandom);
      bus_b.in_valid = 1'($urandom);
      bus_b.sel      = 4'($urandom);
      bus_a.wr_en    = with_writes && ($urandom_range(0, 7) == 0);
      bus_a.wr_addr  = 4'($urandom_range(0, 15));
      bus_a.wr_data  = 16'(int'($urandom_range(0, 65534)) - 32767);
      bus_b.wr_en    = with_writes && ($urandom_range(0, 3) == 0);
      bus_b.wr_addr  = 2'($urandom_range(0, 3));
      bus_b.wr_data  = 8'(int'($urandom_range(0, 254)) - 127);
      tick();
    end
    idle_inputs();
    repeat (20) tick();
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 12; j++) fact[d][j] = 0;
      busy_left[d] = 0;
      last_res[d]  = 0;
    end
    pend.delete();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_busy", {31'b0, bus_a.busy}, 0);
    check("rst_a_in_ready", {31'b0, bus_a.in_ready}, 1);
    check("rst_a_out_valid", {31'b0, bus_a.out_valid}, 0);
    check("rst_a_result", $signed(bus_a.result), 0);
    check("rst_b_out_valid", {31'b0, bus_b.out_valid}, 0);
    check("rst_b_result", $signed(bus_b.result), 0);
    rst = 1'b1;
    tick();

    // Zero table gives zero sum two cycles after acceptance.
    lookup(0, 12'h000);

    // Small configuration: fact = {1,2,3,4}, back-to-back lookups expect 10, -10, -2.
    for (int j = 0; j < 4; j++) write(1, j, j + 1);
    set_lookup(1, 1'b1, 12'hF); tick();
    set_lookup(1, 1'b1, 12'h0); tick();
    set_lookup(1, 1'b1, 12'h5); tick();
    set_lookup(1, 1'b0, 12'h0);
    repeat (3) tick();

    // Extremes: all -128 with every sign positive is -512; all 127 gives +/-508.
    for (int j = 0; j < 4; j++) write(1, j, -128);
    lookup(1, 12'hF);
    for (int j = 0; j < 4; j++) write(1, j, 127);
    lookup(1, 12'hF);
    lookup(1, 12'h0);

    // Dropped writes: one held during busy, then out-of-range addresses.
    for (int j = 0; j < 12; j++) write(0, j, (j + 1) * 111 - 700);
    set_write(0, 3, 1000);
    tick();
    set_write(0, 3, -555);
    repeat (3) tick();
    bus_a.wr_en = 1'b0;
    while (busy_left[0] > 0) tick();
    set_write(0, 13, 777); tick();
    set_write(0, 15, -9);  tick();
    bus_a.wr_en = 1'b0;
    lookup(0, 12'hFFF);
    lookup(0, 12'h008);
    lookup(0, 12'h5A3);

    // Write fact[5] on the same edge as a lookup that uses it, then hold the request.
    write(0, 5, 300);
    set_write(0, 5, 100);
    set_lookup(0, 1'b1, 12'h0A5);
    tick();
    bus_a.wr_en = 1'b0;
    repeat (19) tick();
    set_lookup(0, 1'b0, 12'h0A5);
    repeat (3) tick();

    random_cycles(600, 1'b1);

    // Reset in the middle of a rebuild.
    write(0, 0, 5000);
    lookup(0, 12'hABC);
    set_write(0, 1, 42);
    tick();
    bus_a.wr_en = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("midrst_a_busy", {31'b0, bus_a.busy}, 0);
    check("midrst_a_out_valid", {31'b0, bus_a.out_valid}, 0);
    check("midrst_a_result", $signed(bus_a.result), 0);
    check("midrst_b_result", $signed(bus_b.result), 0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
    random_cycles(30, 1'b0);
    random_cycles(300, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
